// File: rtl/clock_div_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants and types for the multi-channel clock
//                divider (counter width, reset divisor, channel mode).
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    // Default counter width and reset divisor (100 MHz -> 100 kHz toggle)
    localparam int CLK_DIV_CNT_W   = 16;
    localparam int CLK_DIV_DEFAULT = 499;

    // Per-channel output mode
    typedef enum logic {
        CD_TOGGLE = 1'b0,   // 50% duty divided clock on clkout
        CD_TICK   = 1'b1    // single-cycle pulse on tick
    } clk_div_mode_e;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clock_div_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_multi_if
//  Description : Control/status bundle of the multi-channel clock divider.
//                master = controlling logic, slave = divider block.
//  Revision    : 1.0  initial release
// ============================================================================
interface clock_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = CLK_DIV_CNT_W
);
    logic                    en;       // common run enable
    logic                    sync;     // common phase-align strobe
    logic [N_CH-1:0]         load;     // per-channel divisor load strobe
    logic [N_CH*CNT_W-1:0]   div_in;   // packed per-channel divisors
    logic [N_CH-1:0]         mode;     // per-channel mode (0 toggle, 1 tick)
    logic [N_CH-1:0]         clkout;   // toggle-mode divided clocks
    logic [N_CH-1:0]         tick;     // tick-mode pulses

    modport master (
        output en, sync, load, div_in, mode,
        input  clkout, tick
    );

    modport slave (
        input  en, sync, load, div_in, mode,
        output clkout, tick
    );

endinterface : clock_div_multi_if
`default_nettype wire

// File: rtl/clock_div_multi_ch.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ch
//  Description : One divider channel: counter 0..div_q, shadowed divisor
//                reload applied only at period boundaries, toggle/tick
//                output flops.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CLK_DIV_CNT_W,
    parameter int DEFAULT_DIV = CLK_DIV_DEFAULT
)(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    input  clk_div_mode_e    mode_i,
    output logic             clkout_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] div_q,    div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q,   pend_d;
    logic             clkout_q, clkout_d;
    logic             tick_q,   tick_d;
    logic             w_tc;

    // Terminal count: last cycle of the current period
    assign w_tc = en_i && (cnt_q == div_q);

    // Next-state: sync beats terminal count beats normal counting.
    // The divisor only ever changes together with cnt returning to 0 (or
    // while halted, with cnt clamped), so cnt never passes div_q.
    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        clkout_d = clkout_q;
        tick_d   = 1'b0;

        if (sync_i) begin
            cnt_d    = '0;
            clkout_d = 1'b0;
            pend_d   = 1'b0;
            if (load_i) begin
                div_d    = div_i;
                shadow_d = div_i;
            end else if (pend_q) begin
                div_d = shadow_q;
            end
        end else if (w_tc) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (mode_i == CD_TOGGLE) begin
                clkout_d = ~clkout_q;
            end else begin
                tick_d = 1'b1;
            end
            if (load_i) begin
                div_d    = div_i;
                shadow_d = div_i;
            end else if (pend_q) begin
                div_d = shadow_q;
            end
        end else begin
            if (en_i) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (load_i) begin
                // Latest load overwrites any earlier pending value
                shadow_d = div_i;
                pend_d   = 1'b1;
            end else if (!en_i && pend_q) begin
                // Halted: no period boundary will come, apply now
                div_d  = shadow_q;
                pend_d = 1'b0;
                if (cnt_q > shadow_q) begin
                    cnt_d = shadow_q;
                end
            end
        end
    end

    // Channel state registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            div_q    <= C_DEFAULT_DIV;
            shadow_q <= C_DEFAULT_DIV;
            pend_q   <= 1'b0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
        end
    end

    assign clkout_o = clkout_q;
    assign tick_o   = tick_q;

endmodule : clk_div_ch
`default_nettype wire

// File: rtl/clock_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_multi
//  Description : N_CH-channel programmable clock divider / tick generator
//                on a single input clock, with common enable and phase
//                align.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_div_multi
    import clk_div_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = CLK_DIV_CNT_W,
    parameter int DEFAULT_DIV = CLK_DIV_DEFAULT
)(
    input  logic              clkin,
    input  logic              rst_n,
    clock_div_multi_if.slave  bus
);

    wire             w_en;
    wire             w_sync;
    wire [N_CH-1:0]  w_clkout;
    wire [N_CH-1:0]  w_tick;

    // Shared controls fan out to every channel
    assign w_en   = bus.en;
    assign w_sync = bus.sync;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            clk_div_ch #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk_i    (clkin),
                .rst_n_i  (rst_n),
                .en_i     (w_en),
                .sync_i   (w_sync),
                .load_i   (bus.load[k]),
                .div_i    (bus.div_in[k*CNT_W +: CNT_W]),
                .mode_i   (clk_div_mode_e'(bus.mode[k])),
                .clkout_o (w_clkout[k]),
                .tick_o   (w_tick[k])
            );
        end
    endgenerate

    assign bus.clkout = w_clkout;
    assign bus.tick   = w_tick;

endmodule : clock_div_multi
`default_nettype wire
